spi_master_transceiver: RTL and testbench
=========================================

// Module: spi_master_transceiver
// PURPOSE
//  Full-duplex SPI master shift engine that replaces the separate fixed-8-bit sender/receiver pair.
//  Generates SCLK/CS_N from CLK with a programmable divider and supports all four CPOL/CPHA modes.
//  Word width and bit order are parametrised; valid/ready handshake toward the controller.
// PARAMETERS
//  DATA_W     8  bits per transfer (>=2)
//  CLK_DIV    4  CLK cycles per SCLK half-period (>=2)
//  LSB_FIRST  1  1: bit 0 shifted first on MOSI/MISO; 0: bit DATA_W-1 first
// PORTS
//  CLK       in   1       system clock; all logic on posedge
//  CLR_N     in   1       asynchronous active-low reset
//  TX_DATA   in   DATA_W  word to transmit, sampled on accept
//  TX_VALID  in   1       controller has a word
//  TX_READY  out  1       engine idle, can accept
//  CPOL      in   1       SCLK idle level, sampled on accept
//  CPHA      in   1       0: sample on leading edge; 1: sample on trailing edge; sampled on accept
//  RX_DATA   out  DATA_W  last received word, held until next completion
//  RX_VALID  out  1       one-cycle pulse, RX_DATA updated
//  BUSY      out  1       transfer in progress (state != IDLE)
//  SCLK      out  1       serial clock
//  CS_N      out  1       chip select, active low
//  MOSI      out  1       serial data out
//  MISO      in   1       serial data in
// BEHAVIOUR
//  Reset (CLR_N=0, async): IDLE; CS_N=1, SCLK=0, MOSI=0, TX_READY=0, RX_VALID=0, BUSY=0, RX_DATA=0.
//  First posedge after release: TX_READY=1; SCLK tracks CPOL every cycle while IDLE.
//  Accept: TX_VALID & TX_READY on a posedge -> latch TX_DATA, CPOL, CPHA; TX_READY=0, BUSY=1, go LEAD.
//  Divider: counter 0..CLK_DIV-1, cleared on every state entry; terminal count = half-period tick.
//  FSM: IDLE -> LEAD (1 half-period, CS_N=0, SCLK=CPOL) -> XFER (2*DATA_W SCLK edges, one per tick)
//       -> TRAIL (1 half-period, SCLK=CPOL, CS_N=0) -> IDLE.
//  CPHA=0: first bit on MOSI from LEAD entry; MISO sampled on leading edges, MOSI shifts on trailing edges.
//  CPHA=1: MOSI shifts on leading edges (first bit appears at first leading edge); MISO sampled on trailing.
//  Edge counter 0..2*DATA_W-1; XFER exits on the tick producing edge 2*DATA_W-1.
//  Transfer length: accept-to-RX_VALID = (2*DATA_W+2)*CLK_DIV + 1 CLK cycles.
//  TRAIL exit: CS_N=1, RX_DATA loaded, RX_VALID=1 for one cycle, TX_READY=1, BUSY=0 same cycle.
//  Back-to-back: accept possible in the RX_VALID cycle; CS_N high for >=1 CLK between words.
//  MOSI=0 whenever CS_N=1. MISO ignored outside XFER sample edges.
//  TX_VALID while BUSY: ignored, not buffered; TX_DATA/CPOL/CPHA changes mid-transfer have no effect.
//  Reset mid-transfer: immediate abort, outputs to reset values, no RX_VALID, partial data discarded.
// CONFIGURATION
//  SPI_LOOPBACK_EN defined: adds input LOOPBACK (1 bit); when 1 the shift-in path uses internal MOSI
//    instead of MISO (SCLK/CS_N/MOSI still driven); LOOPBACK sampled on accept with CPOL/CPHA.
//  Not defined: no LOOPBACK port; shift-in always from MISO.
// TESTING
//  Mode 0, DATA_W=8, LSB_FIRST=1, CLK_DIV=4: TX 0xA5, MISO drives 0x3C -> MOSI 1,0,1,0,0,1,0,1; RX_DATA=0x3C, RX_VALID at cycle 73.
//  Mode 3, LSB_FIRST=0: TX 0x81, MISO 0x7E -> SCLK idles 1, MOSI MSB first, RX_DATA=0x7E, SCLK back to 1 in IDLE.
//  Back-to-back: TX_VALID held high with 0x11 then 0x22 -> two frames, CS_N high 1 cycle between, RX_VALID twice.
//  Abort: CLR_N=0 at edge 5 of XFER -> CS_N=1 and SCLK=0 same cycle, no RX_VALID, RX_DATA=0.
//  Ignore while busy: TX_VALID toggled during XFER with 0xFF -> only original word sent, TX_READY stays 0.
//  SPI_LOOPBACK_EN, LOOPBACK=1, MISO=0: TX 0xC3 in each mode 0..3 -> RX_DATA=0xC3 every time.

Source files
------------

// File: rtl/spi_master_transceiver.sv
// Full-duplex SPI master shift engine: per-word CPOL/CPHA, parametrised width, divider and bit order.
// Optional feature macro SPI_LOOPBACK_EN adds a LOOPBACK input that routes MOSI back into the receive path.

module spi_master_transceiver #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    input  logic              CPOL,
    input  logic              CPHA,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              BUSY,
    output logic              SCLK,
    output logic              CS_N,
    output logic              MOSI,
    input  logic              MISO,
`ifdef SPI_LOOPBACK_EN
    input  logic              LOOPBACK,
`endif
    output logic [1:0]        o_dbg_state
);

    // Handshake: a word is taken on any posedge with TX_VALID & TX_READY. TX_READY is only high in
    // IDLE and drops on the accept edge; TX_VALID seen while busy is ignored, never buffered.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_cpha;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_mosi;
    logic              r_sclk;
    logic              r_cs_n;
    logic              r_tx_ready;
    logic              r_rx_valid;

    logic              w_accept;
    logic              w_tick;
    logic              w_leading;
    logic              w_shift_edge;
    logic              w_sample_edge;
    logic              w_shift_in;
    logic              w_tx_head;
    logic [DATA_W-1:0] w_rx_next;

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && r_tx_ready && TX_VALID;
    assign w_tick    = (r_div_cnt == DIV_LAST);
    // Even edge indices move SCLK away from its idle level.
    assign w_leading = ~r_edge_cnt[0];
    assign w_shift_edge  = w_tick && (r_state == S_XFER) && (r_cpha ? w_leading : ~w_leading);
    assign w_sample_edge = w_tick && (r_state == S_XFER) && (r_cpha ? ~w_leading : w_leading);
    assign w_tx_head = head_bit(r_tx_sh);
    assign w_rx_next = LSB_FIRST ? {w_shift_in, r_rx_sh[DATA_W-1:1]}
                                 : {r_rx_sh[DATA_W-2:0], w_shift_in};

`ifdef SPI_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_loopback <= 1'b0;
        end else if (w_accept) begin
            r_loopback <= LOOPBACK;
        end
    end

    assign w_shift_in = r_loopback ? r_mosi : MISO;
`else
    assign w_shift_in = MISO;
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_cpha     <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_mosi     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk     <= CPOL;
                    r_mosi     <= 1'b0;
                    r_cs_n     <= 1'b1;
                    r_div_cnt  <= '0;
                    r_edge_cnt <= '0;
                    if (w_accept) begin
                        r_state    <= S_LEAD;
                        r_tx_ready <= 1'b0;
                        r_cs_n     <= 1'b0;
                        r_cpha     <= CPHA;
                        r_rx_sh    <= '0;
                        // CPHA=0 must present the first bit before the first sampling edge.
                        if (CPHA) begin
                            r_tx_sh <= TX_DATA;
                            r_mosi  <= 1'b0;
                        end else begin
                            r_tx_sh <= shift_word(TX_DATA);
                            r_mosi  <= head_bit(TX_DATA);
                        end
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (w_tick) begin
                        r_state   <= S_XFER;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_div_cnt  <= '0;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                        if (w_shift_edge) begin
                            r_mosi  <= w_tx_head;
                            r_tx_sh <= shift_word(r_tx_sh);
                        end
                        if (w_sample_edge) begin
                            r_rx_sh <= w_rx_next;
                        end
                        if (r_edge_cnt == EDGE_LAST) begin
                            r_state    <= S_TRAIL;
                            r_edge_cnt <= '0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_state    <= S_IDLE;
                        r_div_cnt  <= '0;
                        r_cs_n     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_READY    = r_tx_ready;
    assign RX_DATA     = r_rx_data;
    assign RX_VALID    = r_rx_valid;
    assign BUSY        = (r_state != S_IDLE);
    assign SCLK        = r_sclk;
    assign CS_N        = r_cs_n;
    assign MOSI        = r_mosi;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_transceiver.sv
// Directed bench for spi_master_transceiver: an LSB-first and an MSB-first instance driven by a
// cycle-level SPI slave model; expected words and timing are hand-computed constants.

module tb_spi_master_transceiver;

    localparam int LAT_EXP = 73;   // (2*8+2)*4+1, counting the accept edge as edge 1

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] tx_data;
    logic [1:0] tx_valid_v;
    logic       cpol;
    logic       cpha;
    logic [1:0] miso_v;
    logic [1:0] tx_ready_v;
    logic [1:0] rx_valid_v;
    logic [1:0] busy_v;
    logic [1:0] sclk_v;
    logic [1:0] cs_n_v;
    logic [1:0] mosi_v;
    logic [7:0] rx_data0;
    logic [7:0] rx_data1;
    logic [1:0] dbg0;
    logic [1:0] dbg1;
`ifdef SPI_LOOPBACK_EN
    logic       loopback;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_master_transceiver #(.DATA_W(8), .CLK_DIV(4), .LSB_FIRST(1'b1)) dut_lsb (
        .CLK(clk), .CLR_N(clr_n), .TX_DATA(tx_data), .TX_VALID(tx_valid_v[0]),
        .TX_READY(tx_ready_v[0]), .CPOL(cpol), .CPHA(cpha), .RX_DATA(rx_data0),
        .RX_VALID(rx_valid_v[0]), .BUSY(busy_v[0]), .SCLK(sclk_v[0]), .CS_N(cs_n_v[0]),
        .MOSI(mosi_v[0]), .MISO(miso_v[0]),
`ifdef SPI_LOOPBACK_EN
        .LOOPBACK(loopback),
`endif
        .o_dbg_state(dbg0)
    );

    spi_master_transceiver #(.DATA_W(8), .CLK_DIV(4), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(clk), .CLR_N(clr_n), .TX_DATA(tx_data), .TX_VALID(tx_valid_v[1]),
        .TX_READY(tx_ready_v[1]), .CPOL(cpol), .CPHA(cpha), .RX_DATA(rx_data1),
        .RX_VALID(rx_valid_v[1]), .BUSY(busy_v[1]), .SCLK(sclk_v[1]), .CS_N(cs_n_v[1]),
        .MOSI(mosi_v[1]), .MISO(miso_v[1]),
`ifdef SPI_LOOPBACK_EN
        .LOOPBACK(1'b0),
`endif
        .o_dbg_state(dbg1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rx_of(input int d);
        return (d == 0) ? rx_data0 : rx_data1;
    endfunction

    // i-th bit on the wire for the given bit order
    function automatic logic sbit(input logic [7:0] w, input int i, input bit lsb);
        int j;
        j = lsb ? i : 7 - i;
        return w[j[2:0]];
    endfunction

    // Slave model, entered on the negedge right after the accept edge; returns on the RX_VALID negedge.
    task automatic monitor_frame(input int d, input logic pol, input logic pha, input logic [7:0] sl_tx,
                                 input bit junk, output logic [7:0] cap, output int cyc,
                                 output int edges, output int idle_err, output int junk_err);
        int si;
        int mi;
        int k;
        logic prev;
        logic lead;
        bit lsb;
        lsb = (d == 0);
        cap = 8'h00;
        cyc = 1;
        edges = 0;
        idle_err = 0;
        junk_err = 0;
        mi = 0;
        si = pha ? 0 : 1;
        prev = sclk_v[d];
        miso_v[d] = pha ? 1'b0 : sbit(sl_tx, 0, lsb);
        while (cyc < 200 && !rx_valid_v[d]) begin
            @(negedge clk);
            cyc++;
            if (sclk_v[d] !== prev) begin
                lead = (sclk_v[d] !== pol);
                edges++;
                prev = sclk_v[d];
                if (pha ? !lead : lead) begin
                    if (mi < 8) begin
                        k = lsb ? mi : 7 - mi;
                        cap[k[2:0]] = mosi_v[d];
                    end
                    mi++;
                end else begin
                    miso_v[d] = (si < 8) ? sbit(sl_tx, si, lsb) : 1'b0;
                    si++;
                end
            end
            if (cs_n_v[d] && mosi_v[d]) idle_err++;
            if (junk) begin
                if (edges >= 2 && edges < 12) begin
                    tx_valid_v[d] = cyc[0];
                    tx_data = 8'hFF;
                    if (tx_ready_v[d]) junk_err++;
                end else begin
                    tx_valid_v[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_frame(input int d, input string tag, input logic [7:0] tx, input logic [7:0] sl_tx,
                             input logic [7:0] exp_rx, input logic pol, input logic pha, input bit junk);
        logic [7:0] cap;
        int cyc;
        int edges;
        int idle_err;
        int junk_err;
        int w;
        w = 0;
        while (!tx_ready_v[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, tx_ready_v[d], 1);
        cpol = pol;
        cpha = pha;
        @(negedge clk);
        check({tag, "_sclk_idle"}, sclk_v[d], pol);
        tx_data = tx;
        tx_valid_v[d] = 1'b1;
        @(negedge clk);
        tx_valid_v[d] = 1'b0;
        tx_data = ~tx;
        cpha = ~pha;
        check({tag, "_cs_low"}, cs_n_v[d], 0);
        check({tag, "_busy"}, busy_v[d], 1);
        check({tag, "_ready_low"}, tx_ready_v[d], 0);
        monitor_frame(d, pol, pha, sl_tx, junk, cap, cyc, edges, idle_err, junk_err);
        check({tag, "_rx_valid"}, rx_valid_v[d], 1);
        check({tag, "_latency"}, cyc, LAT_EXP);
        check({tag, "_rx_data"}, rx_of(d), exp_rx);
        check({tag, "_mosi_word"}, cap, tx);
        check({tag, "_edges"}, edges, 16);
        check({tag, "_cs_high"}, cs_n_v[d], 1);
        check({tag, "_busy_end"}, busy_v[d], 0);
        check({tag, "_ready_end"}, tx_ready_v[d], 1);
        check({tag, "_sclk_end"}, sclk_v[d], pol);
        check({tag, "_mosi_idle"}, idle_err, 0);
        if (junk) check({tag, "_ready_busy"}, junk_err, 0);
        @(negedge clk);
        check({tag, "_rv_pulse"}, rx_valid_v[d], 0);
        check({tag, "_rx_held"}, rx_of(d), exp_rx);
    endtask

    initial begin
        logic [7:0] cap;
        int cyc;
        int edges;
        int idle_err;
        int junk_err;
        int rv;
        logic prev;

        clr_n = 1'b0;
        tx_data = 8'h00;
        tx_valid_v = 2'b00;
        cpol = 1'b0;
        cpha = 1'b0;
        miso_v = 2'b00;
`ifdef SPI_LOOPBACK_EN
        loopback = 1'b0;
`endif
        #12;
        check("rst_cs_n", cs_n_v, 2'b11);
        check("rst_sclk", sclk_v, 2'b00);
        check("rst_mosi", mosi_v, 2'b00);
        check("rst_tx_ready", tx_ready_v, 2'b00);
        check("rst_rx_valid", rx_valid_v, 2'b00);
        check("rst_busy", busy_v, 2'b00);
        check("rst_rx_data", {rx_data1, rx_data0}, 16'h0000);
        check("rst_state", {dbg1, dbg0}, 4'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("rel_tx_ready", tx_ready_v, 2'b11);

        run_frame(0, "mode0", 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_frame(1, "mode3", 8'h81, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("mode3_sclk_idle_after", sclk_v[1], 1);
        run_frame(0, "busy_ign", 8'h5A, 8'h96, 8'h96, 1'b0, 1'b0, 1'b1);

        // Abort on the fifth SCLK edge of a mode 0 transfer.
        check("abort_rx_before", rx_data0, 8'h96);
        cpol = 1'b0;
        cpha = 1'b0;
        tx_data = 8'h5A;
        miso_v[0] = 1'b1;
        tx_valid_v[0] = 1'b1;
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        edges = 0;
        cyc = 0;
        prev = sclk_v[0];
        while (edges < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sclk_v[0] !== prev) begin
                edges++;
                prev = sclk_v[0];
            end
        end
        check("abort_reached_edge5", edges, 5);
        check("abort_sclk_high", sclk_v[0], 1);
        clr_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n_v[0], 1);
        check("abort_sclk", sclk_v[0], 0);
        check("abort_mosi", mosi_v[0], 0);
        check("abort_busy", busy_v[0], 0);
        check("abort_rx_data", rx_data0, 8'h00);
        check("abort_rx_valid", rx_valid_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        rv = 0;
        repeat (100) begin
            @(negedge clk);
            if (rx_valid_v[0]) rv++;
        end
        check("abort_no_rx_valid", rv, 0);
        check("abort_rx_after", rx_data0, 8'h00);
        check("abort_ready_after", tx_ready_v[0], 1);

        // Back-to-back with TX_VALID held high; TX_DATA changes right after the first accept.
        cpol = 1'b0;
        cpha = 1'b0;
        tx_data = 8'h11;
        tx_valid_v[0] = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;
        check("b2b1_cs_low", cs_n_v[0], 0);
        monitor_frame(0, 1'b0, 1'b0, 8'h33, 1'b0, cap, cyc, edges, idle_err, junk_err);
        check("b2b1_rx_valid", rx_valid_v[0], 1);
        check("b2b1_rx_data", rx_data0, 8'h33);
        check("b2b1_mosi_word", cap, 8'h11);
        check("b2b1_cs_high", cs_n_v[0], 1);
        check("b2b1_ready", tx_ready_v[0], 1);
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        check("b2b_gap_one_cycle", cs_n_v[0], 0);
        check("b2b2_busy", busy_v[0], 1);
        check("b2b2_rv_low", rx_valid_v[0], 0);
        monitor_frame(0, 1'b0, 1'b0, 8'hCC, 1'b0, cap, cyc, edges, idle_err, junk_err);
        check("b2b2_rx_valid", rx_valid_v[0], 1);
        check("b2b2_rx_data", rx_data0, 8'hCC);
        check("b2b2_mosi_word", cap, 8'h22);
        check("b2b2_latency", cyc, LAT_EXP);
        rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (rx_valid_v[0] || !cs_n_v[0]) rv++;
        end
        check("b2b_no_third", rv, 0);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1;
        for (int m = 0; m < 4; m++) begin
            run_frame(0, "loop", 8'hC3, 8'h00, 8'hC3, m[1], m[0], 1'b0);
        end
        loopback = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
